// File: rtl/vscale_debug_hart_ctrl_pkg.sv
// Shared opcode and status encodings for the vscale debug hart run-control engine.
// Only constants live here; each module keeps its own state encoding.
package vscale_debug_hart_ctrl_pkg;

    localparam int DBG_OP_WIDTH     = 2;
    localparam int DBG_STATUS_WIDTH = 2;

    localparam logic [DBG_OP_WIDTH-1:0] DBG_OP_HALT      = 2'd0;
    localparam logic [DBG_OP_WIDTH-1:0] DBG_OP_RESUME    = 2'd1;
    localparam logic [DBG_OP_WIDTH-1:0] DBG_OP_READ_REG  = 2'd2;
    localparam logic [DBG_OP_WIDTH-1:0] DBG_OP_WRITE_REG = 2'd3;

    localparam logic [DBG_STATUS_WIDTH-1:0] DBG_STATUS_OK         = 2'd0;
    localparam logic [DBG_STATUS_WIDTH-1:0] DBG_STATUS_BAD_HART   = 2'd1;
    localparam logic [DBG_STATUS_WIDTH-1:0] DBG_STATUS_NOT_HALTED = 2'd2;
    localparam logic [DBG_STATUS_WIDTH-1:0] DBG_STATUS_TIMEOUT    = 2'd3;

endpackage

// File: rtl/vscale_debug_timeout_ctr.sv
// Wait-cycle counter: flags expiry on the LIMIT-th enabled cycle after a clear.
// Latency: expired is combinational from the count, valid during the final wait cycle.
// Backpressure: none; clear takes priority over enable.
module vscale_debug_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Count holds completed wait cycles, so the current cycle is number count+1.
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/vscale_debug_hart_ctrl.sv
// Multi-hart debug run-control: halt/resume/register access commands to N_HARTS cores.
// Latency: 1 cycle for immediate responses, 2 for register access, ack-bound for halt/resume.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until resp_ready.
module vscale_debug_hart_ctrl
    import vscale_debug_hart_ctrl_pkg::*;
#(
    parameter int N_HARTS     = 4,
    parameter int XPR_LEN     = 32,
    parameter int REGNO_WIDTH = 13,
    parameter int CMD_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [3:0]                 cmd_hartsel,
    input  logic [REGNO_WIDTH-1:0]     cmd_regno,
    input  logic [XPR_LEN-1:0]         cmd_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [1:0]                 resp_status,
    output logic [XPR_LEN-1:0]         resp_rdata,
    output logic [N_HARTS-1:0]         haltreq,
    output logic [N_HARTS-1:0]         resumereq,
    input  logic [N_HARTS-1:0]         halted,
    input  logic [N_HARTS-1:0]         resumeack,
    output logic [REGNO_WIDTH-1:0]     register_index,
    output logic [XPR_LEN-1:0]         debug_wdata,
    output logic [N_HARTS-1:0]         debug_read,
    output logic [N_HARTS-1:0]         debug_write,
    input  logic [N_HARTS*XPR_LEN-1:0] debug_rdata,
    output logic [N_HARTS-1:0]         halted_summary
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_HALT_WAIT   = 3'd1;
    localparam logic [2:0] ST_RESUME_WAIT = 3'd2;
    localparam logic [2:0] ST_ACCESS      = 3'd3;
    localparam logic [2:0] ST_RESP        = 3'd4;

    logic [2:0]         state;
    logic [N_HARTS-1:0] hart_sel;
    logic [N_HARTS-1:0] cmd_onehot;
    logic               cmd_hart_ok;
    logic               cmd_hart_halted;
    logic               cmd_fire;
    logic               timer_en;
    logic               timer_expired;
    logic [XPR_LEN-1:0] rdata_sel;

    assign cmd_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign cmd_fire   = cmd_valid && cmd_ready;

    // Out-of-range hart indices shift the one-hot to zero.
    assign cmd_onehot      = N_HARTS'(1) << cmd_hartsel;
    assign cmd_hart_ok     = 32'(cmd_hartsel) < N_HARTS;
    assign cmd_hart_halted = |(halted & cmd_onehot);

    assign timer_en = (state == ST_HALT_WAIT) || (state == ST_RESUME_WAIT);

    vscale_debug_timeout_ctr #(
        .LIMIT (CMD_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cmd_fire),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        rdata_sel = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (hart_sel[h]) begin
                rdata_sel = rdata_sel | debug_rdata[h*XPR_LEN +: XPR_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halted_summary <= '0;
        end else begin
            halted_summary <= halted;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            hart_sel       <= '0;
            resp_status    <= DBG_STATUS_OK;
            resp_rdata     <= '0;
            haltreq        <= '0;
            resumereq      <= '0;
            debug_read     <= '0;
            debug_write    <= '0;
            register_index <= '0;
            debug_wdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        hart_sel       <= cmd_onehot;
                        register_index <= cmd_regno;
                        debug_wdata    <= cmd_wdata;
                        resp_rdata     <= '0;
                        resp_status    <= DBG_STATUS_OK;
                        if (!cmd_hart_ok) begin
                            resp_status <= DBG_STATUS_BAD_HART;
                            state       <= ST_RESP;
                        end else begin
                            case (cmd_op)
                                DBG_OP_HALT: begin
                                    if (cmd_hart_halted) begin
                                        state <= ST_RESP;
                                    end else begin
                                        haltreq <= cmd_onehot;
                                        state   <= ST_HALT_WAIT;
                                    end
                                end
                                DBG_OP_RESUME: begin
                                    if (!cmd_hart_halted) begin
                                        state <= ST_RESP;
                                    end else begin
                                        resumereq <= cmd_onehot;
                                        state     <= ST_RESUME_WAIT;
                                    end
                                end
                                default: begin
                                    if (!cmd_hart_halted) begin
                                        resp_status <= DBG_STATUS_NOT_HALTED;
                                        state       <= ST_RESP;
                                    end else begin
                                        if (cmd_op == DBG_OP_READ_REG) begin
                                            debug_read <= cmd_onehot;
                                        end else begin
                                            debug_write <= cmd_onehot;
                                        end
                                        state <= ST_ACCESS;
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_HALT_WAIT: begin
                    // An ack in the expiring cycle still counts as success.
                    if (|(halted & hart_sel)) begin
                        haltreq <= '0;
                        state   <= ST_RESP;
                    end else if (timer_expired) begin
                        haltreq     <= '0;
                        resp_status <= DBG_STATUS_TIMEOUT;
                        state       <= ST_RESP;
                    end
                end
                ST_RESUME_WAIT: begin
                    if (|(resumeack & hart_sel)) begin
                        resumereq <= '0;
                        state     <= ST_RESP;
                    end else if (timer_expired) begin
                        resumereq   <= '0;
                        resp_status <= DBG_STATUS_TIMEOUT;
                        state       <= ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    if (|debug_read) begin
                        resp_rdata <= rdata_sel;
                    end
                    debug_read  <= '0;
                    debug_write <= '0;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_debug_hart_ctrl.sv
// Directed bench for vscale_debug_hart_ctrl: halt, register access, error responses,
// resume timeout and ack-at-limit, response backpressure and mid-command reset.
module tb_vscale_debug_hart_ctrl;

    localparam int N_HARTS     = 4;
    localparam int XPR_LEN     = 32;
    localparam int REGNO_WIDTH = 13;
    localparam int CMD_TIMEOUT = 255;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [3:0]                 cmd_hartsel;
    logic [REGNO_WIDTH-1:0]     cmd_regno;
    logic [XPR_LEN-1:0]         cmd_wdata;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [1:0]                 resp_status;
    logic [XPR_LEN-1:0]         resp_rdata;
    logic [N_HARTS-1:0]         haltreq;
    logic [N_HARTS-1:0]         resumereq;
    logic [N_HARTS-1:0]         halted;
    logic [N_HARTS-1:0]         resumeack;
    logic [REGNO_WIDTH-1:0]     register_index;
    logic [XPR_LEN-1:0]         debug_wdata;
    logic [N_HARTS-1:0]         debug_read;
    logic [N_HARTS-1:0]         debug_write;
    logic [N_HARTS*XPR_LEN-1:0] debug_rdata;
    logic [N_HARTS-1:0]         halted_summary;

    int total  = 0;
    int passed = 0;

    vscale_debug_hart_ctrl #(
        .N_HARTS     (N_HARTS),
        .XPR_LEN     (XPR_LEN),
        .REGNO_WIDTH (REGNO_WIDTH),
        .CMD_TIMEOUT (CMD_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_hartsel    (cmd_hartsel),
        .cmd_regno      (cmd_regno),
        .cmd_wdata      (cmd_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_status    (resp_status),
        .resp_rdata     (resp_rdata),
        .haltreq        (haltreq),
        .resumereq      (resumereq),
        .halted         (halted),
        .resumeack      (resumeack),
        .register_index (register_index),
        .debug_wdata    (debug_wdata),
        .debug_read     (debug_read),
        .debug_write    (debug_write),
        .debug_rdata    (debug_rdata),
        .halted_summary (halted_summary)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Presents one command for a single edge; returns in the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [3:0] hart,
                        input logic [REGNO_WIDTH-1:0] regno, input logic [XPR_LEN-1:0] wdata);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_hartsel = hart;
        cmd_regno   = regno;
        cmd_wdata   = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  stable;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_hartsel = 4'd0;
        cmd_regno   = '0;
        cmd_wdata   = '0;
        resp_ready  = 1'b0;
        halted      = '0;
        resumeack   = '0;
        debug_rdata = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
        tick();
        tick();

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_status", resp_status, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_haltreq", haltreq, 0);
        chk("rst_resumereq", resumereq, 0);
        chk("rst_strobes", {debug_read, debug_write}, 0);
        chk("rst_register_index", register_index, 0);
        chk("rst_debug_wdata", debug_wdata, 0);
        chk("rst_halted_summary", halted_summary, 0);
        reset_n = 1'b1;
        tick();

        // HALT hart 2; the hart reports halted during the 5th request cycle.
        send(2'd0, 4'd2, '0, '0);
        chk("halt_req_c1", haltreq, 4'b0100);
        chk("halt_cmd_ready_busy", cmd_ready, 0);
        tick(); tick(); tick();
        chk("halt_req_c4", haltreq, 4'b0100);
        tick();
        halted = 4'b0100;
        chk("halt_req_c5", haltreq, 4'b0100);
        tick();
        chk("halt_req_dropped", haltreq, 0);
        chk("halt_resp_valid", resp_valid, 1);
        chk("halt_resp_status", resp_status, 0);
        chk("halted_summary", halted_summary, 4'b0100);
        consume();
        chk("halt_back_idle", cmd_ready, 1);

        // READ_REG on halted hart 2, then hold the response for 10 cycles.
        send(2'd2, 4'd2, 13'h1008, '0);
        chk("read_strobe", debug_read, 4'b0100);
        chk("read_no_write", debug_write, 0);
        chk("read_regidx", register_index, 13'h1008);
        chk("read_resp_not_yet", resp_valid, 0);
        tick();
        chk("read_resp_valid", resp_valid, 1);
        chk("read_resp_rdata", resp_rdata, 32'hDEADBEEF);
        chk("read_resp_status", resp_status, 0);
        chk("read_strobe_cleared", debug_read, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(resp_valid === 1'b1 && resp_rdata === 32'hDEADBEEF &&
                  resp_status === 2'd0 && cmd_ready === 1'b0)) stable = 1'b0;
        end
        chk("resp_hold_stable", stable, 1);
        consume();
        chk("hold_release_resp_valid", resp_valid, 0);
        chk("hold_release_cmd_ready", cmd_ready, 1);

        // WRITE_REG on halted hart 2.
        send(2'd3, 4'd2, 13'h0300, 32'h12345678);
        chk("write_strobe", debug_write, 4'b0100);
        chk("write_no_read", debug_read, 0);
        chk("write_wdata", debug_wdata, 32'h12345678);
        chk("write_regidx", register_index, 13'h0300);
        tick();
        chk("write_resp_status", resp_status, 0);
        chk("write_resp_rdata", resp_rdata, 0);
        consume();

        // WRITE_REG on running hart 1.
        send(2'd3, 4'd1, 13'h0300, 32'hCAFEF00D);
        chk("nh_strobes", {debug_read, debug_write}, 0);
        chk("nh_resp_valid", resp_valid, 1);
        chk("nh_resp_status", resp_status, 2);
        consume();

        // Out-of-range hart.
        send(2'd0, 4'd5, '0, '0);
        chk("bad_hart_req", {haltreq, resumereq}, 0);
        chk("bad_hart_status", resp_status, 1);
        consume();

        // Trivial cases: resume a running hart, halt an already halted one.
        send(2'd1, 4'd1, '0, '0);
        chk("resume_running_status", {resp_valid, resp_status, resumereq}, {1'b1, 2'd0, 4'b0000});
        consume();
        send(2'd0, 4'd2, '0, '0);
        chk("halt_halted_status", {resp_valid, resp_status, haltreq}, {1'b1, 2'd0, 4'b0000});
        consume();

        // RESUME hart 0 with no ack: request lasts CMD_TIMEOUT cycles.
        halted = 4'b0101;
        send(2'd1, 4'd0, '0, '0);
        chk("resume_req_c1", resumereq, 4'b0001);
        n = 0;
        while (resumereq[0] === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        chk("resume_timeout_cycles", n, 255);
        chk("resume_timeout_resp", {resp_valid, resp_status}, {1'b1, 2'd3});
        chk("resume_timeout_req_low", resumereq, 0);
        consume();

        // RESUME hart 0 with ack arriving in the final allowed cycle.
        send(2'd1, 4'd0, '0, '0);
        for (int i = 0; i < 254; i++) tick();
        chk("resume_ack_last_req", resumereq, 4'b0001);
        resumeack = 4'b0001;
        tick();
        resumeack = 4'b0000;
        chk("resume_ack_last_resp", {resp_valid, resp_status}, {1'b1, 2'd0});
        chk("resume_ack_last_req_low", resumereq, 0);
        consume();

        // Reset while waiting for hart 3 to halt.
        send(2'd0, 4'd3, '0, '0);
        tick();
        chk("rst_mid_req", haltreq, 4'b1000);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_mid_haltreq", haltreq, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid !== 1'b0 || haltreq !== 4'b0000) stable = 1'b0;
        end
        chk("rst_mid_no_resp", stable, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
